// File: rtl/led_pkg.sv
// led_pkg: shared mode encoding and channel limit for the LED pattern generator
package led_pkg;
  typedef enum logic [1:0] {
    LED_OFF     = 2'd0,
    LED_ON      = 2'd1,
    LED_BLINK   = 2'd2,
    LED_BREATHE = 2'd3
  } led_mode_t;
  localparam int LED_MAX_CH = 32;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: one-cycle tick every DIV clocks; clr restarts the count and swallows a pending tick
module tick_prescaler #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;
  always_comb begin
    last  = cnt_q == CW'(DIV - 1);
    tick  = last && !clr;
    cnt_d = (clr || last) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel LED driver with OFF/ON/BLINK/BREATHE modes,
// configured through a one-cycle write port and paced by a shared tick.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int NUM_LEDS        = 10,
  parameter int TICK_DIV        = 50000,
  parameter int HP_W            = 16,
  parameter int DEF_HALF_PERIOD = 500,
  parameter int PWM_BITS        = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sync_i,
  input  logic                      cfg_valid,
  input  logic [$clog2(NUM_LEDS):0] cfg_idx,
  input  logic [1:0]                cfg_mode,
  input  logic [HP_W-1:0]           cfg_hp,
  output logic                      cfg_err,
  output logic                      tick_o,
  output logic [NUM_LEDS-1:0]       led
);
  localparam int IW = $clog2(NUM_LEDS) + 1;
  if (NUM_LEDS < 1 || NUM_LEDS > LED_MAX_CH) begin : g_bad_cfg
    $error("NUM_LEDS out of range");
  end
  logic                tick;
  logic                cfg_err_q, cfg_err_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  tick_prescaler #(.DIV(TICK_DIV)) u_presc (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (sync_i),
    .tick (tick)
  );
  always_comb begin
    cfg_err_d = cfg_valid && (cfg_idx >= IW'(NUM_LEDS));
    pwm_cnt_d = sync_i ? '0 : pwm_cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cfg_err_q <= 1'b0;
      pwm_cnt_q <= '0;
    end else begin
      cfg_err_q <= cfg_err_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  assign cfg_err = cfg_err_q;
  assign tick_o  = tick;
  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_mode_t           mode_q, mode_d;
    logic [HP_W-1:0]     hp_q, hp_d, ph_q, ph_d, eff_hp;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                blink_q, blink_d, down_q, down_d, led_q, led_d, wr, last;
    always_comb begin
      wr      = cfg_valid && cfg_idx == IW'(i);
      eff_hp  = (hp_q == '0) ? HP_W'(1) : hp_q;
      last    = ph_q == eff_hp - 1'b1;
      mode_d  = mode_q;
      hp_d    = hp_q;
      ph_d    = ph_q;
      blink_d = blink_q;
      duty_d  = duty_q;
      down_d  = down_q;
      if (tick && mode_q == LED_BLINK) begin
        ph_d    = last ? '0 : ph_q + 1'b1;
        blink_d = blink_q ^ last;
      end
      // ramp turns around exactly at the end points, never wrapping
      if (tick && mode_q == LED_BREATHE) begin
        duty_d = down_q ? duty_q - 1'b1 : duty_q + 1'b1;
        down_d = down_q ? (duty_d != '0) : (duty_d == '1);
      end
      if (wr) begin
        mode_d = led_mode_t'(cfg_mode);
        hp_d   = cfg_hp;
      end
      if (wr || sync_i) begin
        ph_d    = '0;
        blink_d = 1'b0;
        duty_d  = '0;
        down_d  = 1'b0;
      end
      led_d = (mode_q == LED_ON) || (mode_q == LED_BLINK && blink_q) ||
              (mode_q == LED_BREATHE && pwm_cnt_q < duty_q);
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        mode_q  <= LED_OFF;
        hp_q    <= HP_W'(DEF_HALF_PERIOD);
        ph_q    <= '0;
        blink_q <= 1'b0;
        duty_q  <= '0;
        down_q  <= 1'b0;
        led_q   <= 1'b0;
      end else begin
        mode_q  <= mode_d;
        hp_q    <= hp_d;
        ph_q    <= ph_d;
        blink_q <= blink_d;
        duty_q  <= duty_d;
        down_q  <= down_d;
        led_q   <= led_d;
      end
    assign led[i] = led_q;
  end
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed stimulus with a cycle-stamped expectation queue drained by a negedge monitor
module tb_led_pattern_gen;
  import led_pkg::*;
  logic       clk = 1'b0, rst_n = 1'b0, sync_i = 1'b0, cfg_valid = 1'b0;
  logic [2:0] cfg_idx = '0;
  logic [1:0] cfg_mode = '0;
  logic [7:0] cfg_hp = '0;
  logic       cfg_err, tick_o;
  logic [3:0] led;
  int         cyc = 0, total = 0, bad = 0, pushed = 0;
  bit         done = 1'b0;
  typedef struct {int c; int kind; logic [3:0] val;} exp_t;
  exp_t       sb[$];
  logic [3:0] act;
  string      nm[3] = '{"led", "tick_o", "cfg_err"};
  led_pattern_gen #(
    .NUM_LEDS(4), .TICK_DIV(4), .HP_W(8), .DEF_HALF_PERIOD(3), .PWM_BITS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sync_i(sync_i), .cfg_valid(cfg_valid),
    .cfg_idx(cfg_idx), .cfg_mode(cfg_mode), .cfg_hp(cfg_hp),
    .cfg_err(cfg_err), .tick_o(tick_o), .led(led)
  );
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int tri_w(int k);
    return k <= 15 ? k : k <= 30 ? 30 - k : k <= 45 ? k - 30 : 60 - k;
  endfunction
  function automatic logic [3:0] led_exp(int c);
    int p, k;
    logic [3:0] v;
    v = '0;
    p = c - 1;
    if (c <= 5 || c >= 200) return v;
    if (p < 161) begin
      v[0] = p >= 17 && (((p - 17) / 8 + 1) % 2 == 1);
      v[1] = c >= 22 && c <= 24;
      k    = p >= 29 ? (p - 29) / 4 + 1 : 0;
      v[2] = ((p - 5) % 16) < tri_w(k);
      v[3] = p >= 49 && (((p - 49) / 4 + 1) % 2 == 1);
    end else begin
      k    = p >= 165 ? (p - 165) / 4 + 1 : 0;
      v[0] = k % 2 == 1;
      v[2] = ((p - 161) % 16) < tri_w(k);
      v[3] = v[0];
    end
    return v;
  endfunction
  function automatic logic tick_exp(int c);
    int b;
    if (c <= 5 || (c >= 200 && c <= 203)) return 1'b0;
    b = c <= 160 ? 5 : c < 200 ? 161 : 203;
    return (c - b) % 4 == 3;
  endfunction
  task automatic push(int c, int kind, logic [3:0] v);
    exp_t e;
    e.c = c; e.kind = kind; e.val = v;
    sb.push_back(e);
    pushed++;
  endtask
  task automatic goto(int c);
    while (cyc < c) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic wr(int idx, led_mode_t m, int hp, bit sy);
    cfg_valid = 1'b1;
    cfg_idx   = 3'(idx);
    cfg_mode  = m;
    cfg_hp    = 8'(hp);
    sync_i    = sy;
    @(posedge clk);
    #2;
    cfg_valid = 1'b0;
    sync_i    = 1'b0;
  endtask
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].c <= cyc || done) begin
        act = sb[i].kind == 0 ? led : sb[i].kind == 1 ? {3'b0, tick_o} : {3'b0, cfg_err};
        total++;
        if (sb[i].c != cyc || act !== sb[i].val) begin
          bad++;
          $display("FAIL %s cyc=%0d (checked at %0d) got=%h want=%h",
                   nm[sb[i].kind], sb[i].c, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end
  initial begin
    for (int c = 1; c <= 212; c++) begin
      push(c, 0, led_exp(c));
      if (c != 160) push(c, 1, {3'b0, tick_exp(c)});
      push(c, 2, {3'b0, c == 41});
    end
    goto(5);   rst_n = 1'b1;
    goto(9);   wr(0, LED_BLINK, 2, 1'b0);
    goto(20);  wr(1, LED_ON, 0, 1'b0);
    goto(23);  wr(1, LED_OFF, 0, 1'b0);
    goto(27);  wr(2, LED_BREATHE, 0, 1'b0);
    goto(40);  wr(5, LED_ON, 7, 1'b0);
    goto(45);  wr(3, LED_BLINK, 0, 1'b0);
    goto(160); wr(0, LED_BLINK, 1, 1'b1);
    goto(200); rst_n = 1'b0;
    #1;
    if (led !== 4'b0) begin
      bad++;
      $display("FAIL async reset: led=%h not cleared before clk", led);
    end
    if (tick_o !== 1'b0) begin
      bad++;
      $display("FAIL async reset: tick_o=%b not cleared before clk", tick_o);
    end
    goto(203); rst_n = 1'b1;
    goto(214);
    done = 1'b1;
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard: %0d expectations left unchecked", sb.size());
    end
    if (total != pushed) begin
      bad++;
      $display("FAIL coverage: checked %0d of %0d expectations", total, pushed);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    if (bad == 0) $display("PASS");
    else $display("FAIL %0d mismatches", bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end
endmodule
